// File: rtl/bip_control_unit_if.sv
// rtl/bip_control_unit_if.sv - bus bundle between program memory/datapath and the BIP controller
//
// Purpose : groups the start request, the instruction fetch and the datapath controls.
// Signals : i_start   start request (leaves IDLE)
//           i_instr   program memory word at o_pc
//           o_pc      program counter
//           o_operand IR operand field
//           o_sel_a   accumulator input mux select
//           o_sel_b   ALU B operand select
//           o_op      ALU op (0 add, 1 sub)
//           o_wr_acc  accumulator enable
//           o_wr_ram  data RAM write strobe
//           o_rd_ram  data RAM read strobe
//           o_halted  controller is in HALT
//           o_cycles  FETCH/EXEC cycle counter
// Modports: master = environment (drives start/instr), slave = controller.
interface bip_control_unit_if #(
    parameter int E_BITS   = 16,
    parameter int PC_BITS  = 11,
    parameter int CNT_BITS = 32
);
    logic                i_start;
    logic [E_BITS-1:0]   i_instr;
    logic [PC_BITS-1:0]  o_pc;
    logic [PC_BITS-1:0]  o_operand;
    logic [1:0]          o_sel_a;
    logic                o_sel_b;
    logic                o_op;
    logic                o_wr_acc;
    logic                o_wr_ram;
    logic                o_rd_ram;
    logic                o_halted;
    logic [CNT_BITS-1:0] o_cycles;

    modport master (
        output i_start, i_instr,
        input  o_pc, o_operand, o_sel_a, o_sel_b, o_op,
        input  o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycles
    );

    modport slave (
        input  i_start, i_instr,
        output o_pc, o_operand, o_sel_a, o_sel_b, o_op,
        output o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycles
    );
endinterface

// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - two-phase (FETCH/EXEC) controller for the BIP accumulator datapath
//
// Purpose : fetches the instruction at o_pc, latches it in IR, then drives the
//           datapath strobes and selects for exactly one EXEC cycle.
// Ports   : i_clock  rising-edge clock
//           i_reset  synchronous active-high reset
//           bus      bip_control_unit_if.slave (start, instr in; pc, operand,
//                    selects, strobes, halted, cycle count out)
module bip_control_unit #(
    parameter int E_BITS   = 16,
    parameter int OPC_BITS = 5,
    parameter int PC_BITS  = 11,
    parameter int CNT_BITS = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    bip_control_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [OPC_BITS-1:0] OPC_HLT  = OPC_BITS'(0);
    localparam logic [OPC_BITS-1:0] OPC_STO  = OPC_BITS'(1);
    localparam logic [OPC_BITS-1:0] OPC_LD   = OPC_BITS'(2);
    localparam logic [OPC_BITS-1:0] OPC_LDI  = OPC_BITS'(3);
    localparam logic [OPC_BITS-1:0] OPC_ADD  = OPC_BITS'(4);
    localparam logic [OPC_BITS-1:0] OPC_ADDI = OPC_BITS'(5);
    localparam logic [OPC_BITS-1:0] OPC_SUB  = OPC_BITS'(6);
    localparam logic [OPC_BITS-1:0] OPC_SUBI = OPC_BITS'(7);

    // Accumulator input mux encodings
    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    state_t              state_q,  state_d;
    logic [PC_BITS-1:0]  pc_q,     pc_d;
    logic [E_BITS-1:0]   ir_q,     ir_d;
    logic [CNT_BITS-1:0] cycles_q, cycles_d;

    logic [OPC_BITS-1:0] opcode;

    assign opcode = ir_q[E_BITS-1 -: OPC_BITS];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cycles_q <= cycles_d;
        end
    end

    // Next-state, PC, IR and cycle counter
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cycles_d = cycles_q;

        // The counter only runs while an instruction is in flight and sticks at all-ones.
        if ((state_q == ST_FETCH || state_q == ST_EXEC) && (cycles_q != '1)) begin
            cycles_d = cycles_q + CNT_BITS'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.i_instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode == OPC_HLT) begin
                    // PC stays on the HLT so a debugger sees where execution stopped.
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_q + PC_BITS'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath control decode; everything stays low outside EXEC.
    always_comb begin
        bus.o_sel_a  = SEL_A_RAM;
        bus.o_sel_b  = 1'b0;
        bus.o_op     = 1'b0;
        bus.o_wr_acc = 1'b0;
        bus.o_wr_ram = 1'b0;
        bus.o_rd_ram = 1'b0;

        if (state_q == ST_EXEC) begin
            case (opcode)
                OPC_STO: begin
                    bus.o_wr_ram = 1'b1;
                end
                OPC_LD: begin
                    bus.o_rd_ram = 1'b1;
                    bus.o_sel_a  = SEL_A_RAM;
                    bus.o_wr_acc = 1'b1;
                end
                OPC_LDI: begin
                    bus.o_sel_a  = SEL_A_IMM;
                    bus.o_wr_acc = 1'b1;
                end
                OPC_ADD: begin
                    bus.o_rd_ram = 1'b1;
                    bus.o_sel_b  = 1'b0;
                    bus.o_op     = 1'b0;
                    bus.o_sel_a  = SEL_A_ALU;
                    bus.o_wr_acc = 1'b1;
                end
                OPC_ADDI: begin
                    bus.o_sel_b  = 1'b1;
                    bus.o_op     = 1'b0;
                    bus.o_sel_a  = SEL_A_ALU;
                    bus.o_wr_acc = 1'b1;
                end
                OPC_SUB: begin
                    bus.o_rd_ram = 1'b1;
                    bus.o_sel_b  = 1'b0;
                    bus.o_op     = 1'b1;
                    bus.o_sel_a  = SEL_A_ALU;
                    bus.o_wr_acc = 1'b1;
                end
                OPC_SUBI: begin
                    bus.o_sel_b  = 1'b1;
                    bus.o_op     = 1'b1;
                    bus.o_sel_a  = SEL_A_ALU;
                    bus.o_wr_acc = 1'b1;
                end
                default: begin
                    // HLT and unassigned opcodes drive no strobes.
                end
            endcase
        end
    end

    assign bus.o_pc      = pc_q;
    assign bus.o_operand = ir_q[PC_BITS-1:0];
    assign bus.o_halted  = (state_q == ST_HALT);
    assign bus.o_cycles  = cycles_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - scoreboard bench for bip_control_unit against an instruction-level model
module tb_bip_control_unit;

    localparam int SNAP_W = 62;

    typedef struct {
        logic [SNAP_W-1:0] val;
        logic [SNAP_W-1:0] mask;
        int                tag;
    } exp_t;

    logic clk;
    logic rst;
    logic [15:0] rom [0:2047];

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc_no;

    // Reference model: where the program stands, at instruction granularity
    int          m_mode;   // 0 idle, 1 fetching, 2 executing, 3 halted
    int          m_pc;
    logic [15:0] m_ir;
    longint      m_cyc;

    bip_control_unit_if bus ();

    bip_control_unit dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    assign bus.i_instr = rom[bus.o_pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram} for an executing opcode
    function automatic logic [6:0] ctrl_of(input logic [4:0] opc);
        case (opc)
            5'd1:    return {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            5'd2:    return {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            5'd3:    return {2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            5'd4:    return {2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            5'd5:    return {2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            5'd6:    return {2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            5'd7:    return {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic [15:0] mk(input int opc, input int opnd);
        logic [15:0] w;
        w = {opc[4:0], opnd[10:0]};
        return w;
    endfunction

    task automatic push_expect(input int tag);
        exp_t        e;
        logic [6:0]  ctl;
        logic [10:0] pc11;
        logic [31:0] cyc32;
        ctl   = (m_mode == 2) ? ctrl_of(m_ir[15:11]) : 7'd0;
        pc11  = 11'(m_pc);
        cyc32 = 32'(m_cyc);
        e.val  = {pc11, m_ir[10:0], ctl, (m_mode == 3), cyc32};
        // The operand field only has meaning once an instruction has been latched for execution.
        e.mask = '1;
        if (m_mode < 2) e.mask[50:40] = '0;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic model_edge(input bit start, input bit reset, input int tag);
        if (reset) begin
            m_mode = 0;
            m_pc   = 0;
            m_ir   = '0;
            m_cyc  = 0;
        end else begin
            if ((m_mode == 1 || m_mode == 2) && m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    m_ir   = rom[m_pc];
                    m_mode = 2;
                end
                2: begin
                    if (m_ir[15:11] == 5'd0) m_mode = 3;
                    else begin
                        m_pc   = (m_pc + 1) % 2048;
                        m_mode = 1;
                    end
                end
                default: ;
            endcase
        end
        push_expect(tag);
    endtask

    task automatic cycle(input bit start, input bit reset, input int tag);
        bus.i_start = start;
        rst         = reset;
        @(posedge clk);
        #1;
        cyc_no++;
        model_edge(start, reset, tag);
    endtask

    task automatic rom_fill_halt();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    endtask

    // Monitor: every cycle the DUT presents a full output snapshot; compare it at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [SNAP_W-1:0] act;
            e   = exp_q.pop_front();
            act = {bus.o_pc, bus.o_operand, bus.o_sel_a, bus.o_sel_b, bus.o_op,
                   bus.o_wr_acc, bus.o_wr_ram, bus.o_rd_ram, bus.o_halted, bus.o_cycles};
            checks++;
            if (((act ^ e.val) & e.mask) !== '0) begin
                errors++;
                $display("FAIL snap test%0d t=%0t got pc=%h opnd=%h ctl=%b halt=%b cyc=%0d want pc=%h opnd=%h ctl=%b halt=%b cyc=%0d",
                         e.tag, $time, act[61:51], act[50:40], act[39:33], act[32], act[31:0],
                         e.val[61:51], e.val[50:40], e.val[39:33], e.val[32], e.val[31:0]);
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        cyc_no      = 0;
        m_mode      = 0;
        m_pc        = 0;
        m_ir        = '0;
        m_cyc       = 0;
        bus.i_start = 1'b0;
        rst         = 1'b1;
        rom_fill_halt();

        // 1: reset, then idle with no start
        repeat (2) cycle(0, 1, 1);
        repeat (5) cycle(0, 0, 1);

        // 2: LDI 5, ADDI 3, STO 7, HLT
        rom[0] = mk(3, 5);
        rom[1] = mk(5, 3);
        rom[2] = mk(1, 7);
        rom[3] = mk(0, 0);
        cycle(1, 0, 2);
        repeat (12) cycle(0, 0, 2);

        // 3: SUB 4 then an unassigned opcode, then HLT
        repeat (2) cycle(0, 1, 3);
        rom_fill_halt();
        rom[0] = mk(6, 4);
        rom[1] = mk(31, 1234);
        cycle(1, 0, 3);
        repeat (8) cycle(0, 0, 3);

        // 4: a full memory of NOPs so the PC wraps 2047 -> 0 and keeps going
        repeat (2) cycle(0, 1, 4);
        for (int i = 0; i < 2048; i++) rom[i] = mk($urandom_range(8, 31), $urandom_range(0, 2047));
        cycle(1, 0, 4);
        repeat (2 * 2052) cycle(0, 0, 4);

        // 5: reset lands while an ADD is executing
        repeat (2) cycle(0, 1, 5);
        rom_fill_halt();
        rom[0] = mk(4, 9);
        cycle(1, 0, 5);
        cycle(0, 0, 5);
        cycle(0, 1, 5);
        repeat (3) cycle(0, 0, 5);

        // 6: halted controller ignores start; reset then start restarts at PC 0
        rom_fill_halt();
        for (int i = 0; i < 6; i++) rom[i] = mk($urandom_range(1, 7), $urandom_range(0, 2047));
        cycle(1, 0, 6);
        repeat (20) cycle(0, 0, 6);
        for (int i = 0; i < 10; i++) cycle(i % 2 == 0, 0, 6);
        repeat (2) cycle(0, 1, 6);
        cycle(1, 0, 6);
        repeat (6) cycle(1, 0, 6);

        // Random programs with random start activity and occasional resets
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 2048; i++) begin
                int opc;
                opc = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 31);
                rom[i] = mk(opc, $urandom_range(0, 2047));
            end
            repeat (2) cycle(0, 1, 10 + t);
            for (int c = 0; c < 300; c++) begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0, 10 + t);
            end
        end

        bus.i_start = 1'b0;
        rst         = 1'b0;
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending snapshots want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
